regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the single-write register file for the dual-issue pipeline.
- Provides 2 combinational read ports and 2 write ports with fixed priority.
- Adds a per-register busy scoreboard: set at issue, cleared at writeback. Decode uses it to generate RAW stall signals.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width; NREG = 2**AW registers.
- RESET_IDX, 1, when 1 register i resets to value i (zero-extended/truncated to DW); when 0 all registers reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- regA  in  AW  read port A address.
- regB  in  AW  read port B address.
- Adat  out  DW  read port A data.
- Bdat  out  DW  read port B data.
- Astall  out  1  regA is busy (pending writer).
- Bstall  out  1  regB is busy (pending writer).
- IssueEn  in  1  mark regI busy.
- regI  in  AW  destination register of the issued instruction.
- We0  in  1  write port 0 enable.
- regW0  in  AW  write port 0 address.
- Wdat0  in  DW  write port 0 data.
- We1  in  1  write port 1 enable.
- regW1  in  AW  write port 1 address.
- Wdat1  in  DW  write port 1 data.
- BusyVec  out  NREG  scoreboard contents, bit i = register i busy.

Interface decision (already decided): one clock, clk; reset Rst is asynchronous and active-high.

Behaviour:
- Reset (async, immediate):
  - Registers take RESET_IDX values.
  - BusyVec = 0, hence Astall = Bstall = 0.
  - Adat/Bdat reflect the reset contents combinationally: with RESET_IDX=1, Adat = regA.
- Register 0: reads always 0; writes to it are ignored; issue to it is ignored; busy[0] is always 0.
- Reads: combinational from the array, zero latency.
- Writes take effect at the rising edge of clk.
  - Both ports enabled to the same nonzero address: port 1 wins, port 0 is dropped.
  - Different addresses: both are written.
- Scoreboard at each edge, per register r != 0:
  - set = IssueEn && regI == r.
  - clr = (We0 && regW0 == r) || (We1 && regW1 == r).
  - busy_next = set ? 1 : (clr ? 0 : busy).
  - Same-cycle issue and writeback of the same register leaves it busy, because the new writer is younger.
- Issue to a register that is already busy keeps it busy (WAW tolerated; single bit, no counter).
- Writeback to a non-busy register writes data and leaves busy at 0.
- Astall = busy[regA], qualified by bypass (see Optional Feature); same rule for Bstall with regB.
- Reset asserted mid-operation discards all pending writes and the scoreboard within the same cycle. The first edge after Rst deasserts behaves normally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If We1 && regW1 == regA != 0, then Adat = Wdat1.
  - Else if We0 && regW0 == regA != 0, then Adat = Wdat0.
  - Astall is forced to 0 in either bypass case.
  - Same rules apply to port B.
  - This adds a combinational path from Wdat to Adat/Bdat.
- Undefined:
  - Reads return array contents only; same-cycle writes are visible next cycle.
  - Astall/Bstall remain asserted in the writeback cycle.

Decomposition:
- Package rf_pkg holds:
  - default DW/AW constants;
  - typedef rf_addr_t (AW bits) and rf_data_t (DW bits);
  - constant RF_ZERO_REG = 0.
- One sub-module, rf_scoreboard:
  - NREG busy flops plus set/clear logic;
  - inputs: IssueEn/regI, both write enables/addresses;
  - outputs: BusyVec.
- The top level holds the data array, read muxes, bypass and stall generation.

Test Plan:
- Pulse Rst with RESET_IDX=1, regA=7, regB=31 -> Adat=7, Bdat=31, BusyVec=0, Astall=0.
- We0=1, regW0=0, Wdat0=0xFFFFFFFF; next cycle regA=0 -> Adat=0, BusyVec[0]=0.
- Same edge: We0 to r5 with 0x11, We1 to r5 with 0x22; next cycle regA=5 -> Adat=0x22.
- IssueEn to r9 at cycle n, regA=9 -> Astall=1 from n+1.
  - We0 to r9 with 0xABCD at cycle n+3 -> with REGFILE_BYPASS_EN: Adat=0xABCD and Astall=0 during n+3; without: Astall=1 during n+3, then Adat=0xABCD and Astall=0 at n+4.
- Same edge: IssueEn to r4 and We1 to r4 -> BusyVec[4]=1 after the edge, and r4 holds the new data.
- Issue r3 and r6; assert Rst asynchronously between edges -> BusyVec=0 immediately, Adat(regA=3)=3; after deassert, writes resume normally.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths match the dual-issue pipeline's 32 x 32-bit integer file.
package rf_pkg;

    localparam int RF_DW       = 32;
    localparam int RF_AW       = 5;
    localparam int RF_NREG     = 1 << RF_AW;
    localparam int RF_ZERO_REG = 0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set when an instruction issues to the register,
// cleared when either writeback port writes it. Register 0 is never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 IssueEn,
    input  logic [AW-1:0]        regI,
    input  logic                 We0,
    input  logic [AW-1:0]        regW0,
    input  logic                 We1,
    input  logic [AW-1:0]        regW1,
    output logic [(1<<AW)-1:0]   BusyVec
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Bit 0 of both vectors stays low, so busy[0] can never leave reset value.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            set_vec[r] = IssueEn && (regI == AW'(r));
            clr_vec[r] = (We0 && (regW0 == AW'(r))) || (We1 && (regW1 == AW'(r)));
        end
    end

    // Set beats clear: a same-cycle issue belongs to a younger writer.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            BusyVec <= '0;
        end else begin
            BusyVec <= set_vec | (BusyVec & ~clr_vec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with RAW busy scoreboard for decode.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DW        = RF_DW,
    parameter int AW        = RF_AW,
    parameter int RESET_IDX = 1
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic [AW-1:0]        regA,
    input  logic [AW-1:0]        regB,
    output logic [DW-1:0]        Adat,
    output logic [DW-1:0]        Bdat,
    output logic                 Astall,
    output logic                 Bstall,
    input  logic                 IssueEn,
    input  logic [AW-1:0]        regI,
    input  logic                 We0,
    input  logic [AW-1:0]        regW0,
    input  logic [DW-1:0]        Wdat0,
    input  logic                 We1,
    input  logic [AW-1:0]        regW1,
    input  logic [DW-1:0]        Wdat1,
    output logic [(1<<AW)-1:0]   BusyVec
);

    localparam int            NREG = 1 << AW;
    localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

    logic [DW-1:0] regs [NREG];

    // Port 1 has priority on an address collision; entry 0 is never written.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (RESET_IDX != 0) ? DW'(i) : '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (We1 && (regW1 == AW'(i))) begin
                    regs[i] <= Wdat1;
                end else if (We0 && (regW0 == AW'(i))) begin
                    regs[i] <= Wdat0;
                end
            end
        end
    end

    rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk     (clk),
        .Rst     (Rst),
        .IssueEn (IssueEn),
        .regI    (regI),
        .We0     (We0),
        .regW0   (regW0),
        .We1     (We1),
        .regW1   (regW1),
        .BusyVec (BusyVec)
    );

    logic [DW-1:0] arr_a;
    logic [DW-1:0] arr_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          hit_a;
    logic          hit_b;

    assign arr_a = (regA == ZERO) ? '0 : regs[regA];
    assign arr_b = (regB == ZERO) ? '0 : regs[regB];

`ifdef REGFILE_BYPASS_EN
    // Forwarding mirrors the write priority so reads match next-cycle contents.
    always_comb begin
        hit_a = 1'b0;
        fwd_a = '0;
        if (regA != ZERO) begin
            if (We1 && (regW1 == regA)) begin
                hit_a = 1'b1;
                fwd_a = Wdat1;
            end else if (We0 && (regW0 == regA)) begin
                hit_a = 1'b1;
                fwd_a = Wdat0;
            end
        end
    end

    always_comb begin
        hit_b = 1'b0;
        fwd_b = '0;
        if (regB != ZERO) begin
            if (We1 && (regW1 == regB)) begin
                hit_b = 1'b1;
                fwd_b = Wdat1;
            end else if (We0 && (regW0 == regB)) begin
                hit_b = 1'b1;
                fwd_b = Wdat0;
            end
        end
    end
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    assign Adat   = hit_a ? fwd_a : arr_a;
    assign Bdat   = hit_b ? fwd_b : arr_b;
    assign Astall = BusyVec[regA] & ~hit_a;
    assign Bstall = BusyVec[regB] & ~hit_b;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic,
// with a reference model feeding an expected-value queue every cycle.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        Rst;
    logic [4:0]  regA, regB, regI, regW0, regW1;
    logic [31:0] Adat, Bdat, Wdat0, Wdat1, BusyVec;
    logic        Astall, Bstall, IssueEn, We0, We1;

    always #5 clk = ~clk;

    regfile_sb #(.DW(32), .AW(5), .RESET_IDX(1)) dut (
        .clk(clk), .Rst(Rst),
        .regA(regA), .regB(regB), .Adat(Adat), .Bdat(Bdat),
        .Astall(Astall), .Bstall(Bstall),
        .IssueEn(IssueEn), .regI(regI),
        .We0(We0), .regW0(regW0), .Wdat0(Wdat0),
        .We1(We1), .regW1(regW1), .Wdat1(Wdat1),
        .BusyVec(BusyVec)
    );

    logic [31:0] exp_q[$];
    logic [31:0] m_reg[32];
    logic [31:0] m_busy;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
        m_busy = '0;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (We1 && regW1 == a) return Wdat1;
        if (We0 && regW0 == a) return Wdat0;
`endif
        return m_reg[a];
    endfunction

    function automatic logic m_st(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((We1 && regW1 == a) || (We0 && regW0 == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_edge();
        logic [31:0] nb;
        nb = m_busy;
        if (We1 && regW1 != 5'd0) m_reg[regW1] = Wdat1;
        if (We0 && regW0 != 5'd0 && !(We1 && regW1 == regW0)) m_reg[regW0] = Wdat0;
        for (int r = 1; r < 32; r++) begin
            if (IssueEn && regI == 5'(r)) nb[r] = 1'b1;
            else if ((We0 && regW0 == 5'(r)) || (We1 && regW1 == 5'(r))) nb[r] = 1'b0;
        end
        m_busy = nb;
    endtask

    task automatic drive(input logic ie, input logic [4:0] ri,
                         input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        IssueEn = ie; regI = ri;
        We0 = w0; regW0 = a0; Wdat0 = d0;
        We1 = w1; regW1 = a1; Wdat1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Expected outputs for the stimulus currently applied, then compared after settling.
    task automatic push_expect();
        exp_q.push_back(m_rd(regA));
        exp_q.push_back(m_rd(regB));
        exp_q.push_back({31'd0, m_st(regA)});
        exp_q.push_back({31'd0, m_st(regB)});
        exp_q.push_back(m_busy);
    endtask

    task automatic compare_outputs(input string tag);
        #1;
        if (exp_q.size() < 5) begin
            check({tag, ".queue"}, 32'(exp_q.size()), 32'd5);
        end else begin
            check({tag, ".adat"},   Adat,            exp_q.pop_front());
            check({tag, ".bdat"},   Bdat,            exp_q.pop_front());
            check({tag, ".astall"}, {31'd0, Astall}, exp_q.pop_front());
            check({tag, ".bstall"}, {31'd0, Bstall}, exp_q.pop_front());
            check({tag, ".busy"},   BusyVec,         exp_q.pop_front());
        end
    endtask

    task automatic do_cycle(input string tag);
        push_expect();
        compare_outputs(tag);
        @(posedge clk);
        if (!Rst) model_edge();
        @(negedge clk);
    endtask

    initial begin
        Rst = 1'b1;
        regA = 5'd7; regB = 5'd31;
        idle();
        model_reset();
        #12;
        check("rst.adat",   Adat, 32'd7);
        check("rst.bdat",   Bdat, 32'd31);
        check("rst.busy",   BusyVec, 32'd0);
        check("rst.astall", {31'd0, Astall}, 32'd0);
        @(negedge clk);
        Rst = 1'b0;

        // Writes to register 0 are dropped.
        regA = 5'd0;
        drive(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        do_cycle("zero_wr");
        idle();
        #1;
        check("zero.adat",  Adat, 32'd0);
        check("zero.busy0", {31'd0, BusyVec[0]}, 32'd0);
        do_cycle("zero_rd");

        // Same-address collision: port 1 wins.
        drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        do_cycle("prio_wr");
        idle(); regA = 5'd5;
        #1;
        check("prio.adat", Adat, 32'h22);
        do_cycle("prio_rd");

        // Issue r9, write it back three cycles later.
        regA = 5'd9;
        drive(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_cycle("raw_n");
        idle();
        #1;
        check("raw_n1.astall", {31'd0, Astall}, 32'd1);
        do_cycle("raw_n1");
        do_cycle("raw_n2");
        drive(1'b0, 5'd0, 1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw_n3.adat",   Adat, 32'hABCD);
        check("raw_n3.astall", {31'd0, Astall}, 32'd0);
`else
        check("raw_n3.astall", {31'd0, Astall}, 32'd1);
`endif
        do_cycle("raw_n3");
        idle();
        #1;
        check("raw_n4.adat",   Adat, 32'hABCD);
        check("raw_n4.astall", {31'd0, Astall}, 32'd0);
        do_cycle("raw_n4");

        // Same-edge issue and writeback of r4 leaves it busy with new data.
        drive(1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444);
        do_cycle("iw_same");
        idle(); regA = 5'd4;
        #1;
        check("iw.busy4", {31'd0, BusyVec[4]}, 32'd1);
        check("iw.adat",  Adat, 32'h4444);
        do_cycle("iw_rd");

        // Async reset between edges discards scoreboard and a pending write.
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_cycle("ar_i3");
        drive(1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_cycle("ar_i6");
        regA = 5'd3; regB = 5'd6;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        #1;
        check("ar.pre_busy", BusyVec & 32'h0000_0058, 32'h0000_0058);
        #1;
        Rst = 1'b1;
        #1;
        check("ar.busy",   BusyVec, 32'd0);
        check("ar.adat",   Adat, 32'd3);
        check("ar.astall", {31'd0, Astall}, 32'd0);
        model_reset();
        @(negedge clk);
        Rst = 1'b0;
        idle();
        #1;
        check("ar.bdat_discard", Bdat, 32'd6);
        do_cycle("ar_post");
        drive(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        do_cycle("ar_wr");
        idle();
        #1;
        check("ar.resume", Adat, 32'h33);
        do_cycle("ar_rd");

        // Random traffic over a small address window to force collisions.
        for (int c = 0; c < 400; c++) begin
            regA = 5'($urandom_range(0, 7));
            regB = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            do_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
